// File: rtl/sensor_stream_packer.sv
// sensor_stream_packer: packs an fv/lv/8-bit pixel stream into 32-bit AXI4-Stream words.
//  Four pixels per word, first pixel in [7:0]. tuser flags the first word of a frame and
//  tlast the last word of each line. A first-word-fall-through FIFO absorbs backpressure.
//  When the FIFO overflows, the rest of that frame is discarded and capture resumes at the
//  next frame. Sticky overflow/size_err flags are provided for CPU readback.
// Ports:
//  pixclk, reset_n                     clock, asynchronous active-low reset
//  enable                              capture enable, sampled at frame start
//  in_fv, in_lv, in_pix_data           sensor stream input
//  m_axis_tdata/tvalid/tready/tlast/tuser   AXI4-Stream master
//  clr_status                          clears overflow and size_err
//  overflow, size_err                  sticky status flags
//  fifo_level                          FIFO occupancy in words
//  frame_cnt, line_cnt_last            frame statistics (only with PACKER_FRAME_STATS_EN)
// Optional feature macro: PACKER_FRAME_STATS_EN
module sensor_stream_packer #(
    parameter int unsigned IMG_WIDTH  = 1296,
    parameter int unsigned IMG_HEIGHT = 972,
    parameter int unsigned FIFO_DEPTH = 512
) (
    input  logic                              pixclk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              in_fv,
    input  logic                              in_lv,
    input  logic [7:0]                        in_pix_data,
    output logic [31:0]                       m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tuser,
    input  logic                              clr_status,
    output logic                              overflow,
    output logic                              size_err,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic [15:0]                       frame_cnt,
    output logic [11:0]                       line_cnt_last
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = $clog2(IMG_WIDTH + 2);
    localparam int unsigned FW = 34;

    typedef enum logic [1:0] {IDLE, ACTIVE, SKIP, DROP} state_t;

    state_t state, state_nx;

    logic         fv_r, lv_r, en_r, fv_d, lvq_d, seen_low;
    logic [7:0]   pix_r;
    logic         lv_q, lv_fall, fv_rise, fv_fall;
    logic         start, pix_ok, line_end, frame_end;
    logic [PW-1:0] pix_cnt, pix_cnt_inc;
    logic [11:0]  line_cnt, lines_now;
    logic [1:0]   pk_cnt;
    logic [23:0]  pk_data;
    logic         user_arm;
    logic         st_valid, st_last, st_user;
    logic [31:0]  st_data;
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic         pop, push_req, full, drop, wr;
    logic [FW-1:0] push_word, head_word;

    // Input capture and edge history; seen_low blocks a false rise when fv is high at reset release
    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            fv_r     <= 1'b0;
            lv_r     <= 1'b0;
            en_r     <= 1'b0;
            pix_r    <= 8'h00;
            fv_d     <= 1'b0;
            lvq_d    <= 1'b0;
            seen_low <= 1'b0;
        end else begin
            fv_r     <= in_fv;
            lv_r     <= in_lv;
            en_r     <= enable;
            pix_r    <= in_pix_data;
            fv_d     <= fv_r;
            lvq_d    <= lv_q;
            seen_low <= seen_low | ~in_fv;
        end
    end

    assign lv_q     = fv_r & lv_r;
    assign lv_fall  = lvq_d & ~lv_q;
    assign fv_rise  = fv_r & ~fv_d & seen_low;
    assign fv_fall  = fv_d & ~fv_r;

    assign start     = (state == IDLE) && fv_rise && en_r;
    assign pix_ok    = (state == ACTIVE) && lv_q;
    assign line_end  = (state == ACTIVE) && lv_fall;
    assign frame_end = (state == ACTIVE) && fv_fall;
    assign lines_now = line_cnt + 12'(line_end);
    // Saturates one past the line width so over-length lines stay distinguishable
    assign pix_cnt_inc = (pix_cnt == PW'(IMG_WIDTH + 1)) ? pix_cnt : pix_cnt + PW'(1);

    // FIFO control: a pop in the same cycle frees the slot for the incoming word
    assign pop       = (count != '0) && m_axis_tready;
    assign push_req  = st_valid && (state != DROP);
    assign full      = (count == LW'(FIFO_DEPTH));
    assign drop      = push_req && full && !pop;
    assign wr        = push_req && !drop;
    // A line ending right after a completed word marks that word as last of the line
    assign push_word = {st_user, st_last | lv_fall, st_data};

    // State register
    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic; frame end takes priority over a same-cycle overflow
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (fv_rise) state_nx = en_r ? ACTIVE : SKIP;
            ACTIVE: begin
                if (fv_fall)   state_nx = IDLE;
                else if (drop) state_nx = DROP;
            end
            SKIP:     if (fv_fall) state_nx = IDLE;
            DROP:     if (fv_fall) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Byte packer and one-word staging register feeding the FIFO
    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            pk_cnt   <= 2'd0;
            pk_data  <= 24'h0;
            pix_cnt  <= '0;
            line_cnt <= 12'd0;
            user_arm <= 1'b0;
            st_valid <= 1'b0;
            st_last  <= 1'b0;
            st_user  <= 1'b0;
            st_data  <= 32'h0;
        end else begin
            st_valid <= 1'b0;
            if (start) begin
                pk_cnt   <= 2'd0;
                pk_data  <= 24'h0;
                pix_cnt  <= '0;
                line_cnt <= 12'd0;
                user_arm <= 1'b1;
            end else begin
                if (pix_ok) begin
                    pix_cnt <= pix_cnt_inc;
                    if (pk_cnt == 2'd3) begin
                        st_valid <= 1'b1;
                        st_data  <= {pix_r, pk_data};
                        st_last  <= (pix_cnt_inc == PW'(IMG_WIDTH));
                        st_user  <= user_arm;
                        user_arm <= 1'b0;
                        pk_data  <= 24'h0;
                        pk_cnt   <= 2'd0;
                    end else begin
                        pk_data[{pk_cnt, 3'b000} +: 8] <= pix_r;
                        pk_cnt <= pk_cnt + 2'd1;
                    end
                end
                if (line_end) begin
                    pix_cnt  <= '0;
                    line_cnt <= line_cnt + 12'd1;
                    // Short line tail: flush held bytes zero-padded
                    if (pk_cnt != 2'd0) begin
                        st_valid <= 1'b1;
                        st_data  <= {8'h00, pk_data};
                        st_last  <= 1'b1;
                        st_user  <= user_arm;
                        user_arm <= 1'b0;
                        pk_data  <= 24'h0;
                        pk_cnt   <= 2'd0;
                    end
                end
            end
        end
    end

    // FIFO storage (no reset needed; reads are masked while empty)
    always_ff @(posedge pixclk) begin
        if (wr) mem[wr_ptr] <= push_word;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(wr) - LW'(pop);
        end
    end

    assign head_word     = (count != '0) ? mem[rd_ptr] : '0;
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = head_word[31:0];
    assign m_axis_tlast  = head_word[32];
    assign m_axis_tuser  = head_word[33];
    assign fifo_level    = count;

    // Sticky status; a set event beats a same-cycle clear
    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            size_err <= 1'b0;
        end else begin
            overflow <= drop | (overflow & ~clr_status);
            size_err <= (line_end && (pix_cnt != PW'(IMG_WIDTH)))
                      | (frame_end && (lines_now != 12'(IMG_HEIGHT)))
                      | (size_err & ~clr_status);
        end
    end

`ifdef PACKER_FRAME_STATS_EN
    // Frame statistics: only frames ending cleanly in ACTIVE are counted
    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt     <= 16'd0;
            line_cnt_last <= 12'd0;
        end else if (frame_end) begin
            if (!drop) frame_cnt <= frame_cnt + 16'd1;
            line_cnt_last <= lines_now;
        end
    end
`else
    assign frame_cnt     = 16'd0;
    assign line_cnt_last = 12'd0;
`endif

endmodule
